sr04_scheduler: RTL
===================

# sr04_scheduler

Round-robin measurement scheduler for up to CHANNELS HC-SR04 ultrasonic sensors sharing one timing datapath: one microsecond prescaler, one centimetre prescaler and one range counter. It fires one sensor at a time to avoid acoustic crosstalk and measures its echo pulse in centimetres. It stores a per-channel result and inserts a guard gap before moving to the next enabled channel. It sits between the board sensor pins and the display/readout logic, and replaces per-sensor receiver instances when several sensors are fitted.

## Interface
- CHANNELS, 4, number of sensors, 1..8
- RANGE_WIDTH, 16, result width in cm
- DELAY_CLK_1US, 50, clocks per microsecond
- DELAY_1US_1SM, 58, microseconds of echo per centimetre
- DELAY_TRIGGER_US, 10, trigger pulse length in µs
- DELAY_ECHO_US, 23200, timeout for echo start and for echo length, in µs
- DELAY_GAP_US, 60000, guard time after each measurement, in µs
- clk  input  1  system clock; the block uses this single clock
- rst_n  input  1  asynchronous, active-low reset
- ch_en  input  CHANNELS  channel enable mask
- echo  input  CHANNELS  raw asynchronous echo pins
- trigger  output  CHANNELS  trigger pins; at most one bit is high at any time
- range  output  CHANNELS*RANGE_WIDTH  per-channel result in cm; channel i occupies bits [i*RANGE_WIDTH +: RANGE_WIDTH]
- timeout  output  CHANNELS  per-channel flag: the last measurement on that channel timed out
- done  output  1  one-cycle pulse when a result is written
- done_ch  output  $clog2(CHANNELS) (minimum 1)  channel index qualified by done

## Operation
- Each echo bit passes through a 2-flop synchronizer. Only the echo of the current channel `ch` is used.
- State machine states: IDLE, TRIG, WAIT, MEAS, GAP.
- **IDLE**
  - Selects the lowest enabled channel at index ≥ ch, wrapping to 0. Ties are impossible.
  - With ch_en == 0 the FSM stays in IDLE.
  - On the first selection after reset the search starts at index 0.
- **TRIG**
  - trigger[ch] is high for DELAY_TRIGGER_US µs.
- **WAIT**
  - On a synchronized echo rising edge: go to MEAS.
  - After DELAY_ECHO_US µs with no rising edge: result := 0, timeout[ch] := 1, go to GAP.
- **MEAS**
  - The range counter increments on each cm strobe. It saturates at all-ones and does not wrap.
  - On echo falling: result := count, timeout[ch] := 0, go to GAP.
  - After DELAY_ECHO_US µs: result := count, timeout[ch] := 1, go to GAP.
- **GAP**
  - Waits DELAY_GAP_US µs, then sets ch := ch+1 (wrapping at CHANNELS) and returns to IDLE.
- The result write and the done/done_ch pulse occur in the cycle the FSM leaves WAIT or MEAS. They happen exactly once per measurement.
- The µs prescaler, µs duration counter and cm prescaler all clear on every state entry, so state durations are exact.
- A ch_en change during a measurement does not abort it. The mask is only evaluated in IDLE.
- An echo already high on entry to WAIT is not a rising edge. It must fall and rise again before MEAS is entered.

## Timing
- Reset values: trigger = 0, range = 0, timeout = 0, done = 0, done_ch = 0, FSM in IDLE, ch = 0.
- Reset asserted mid-measurement drops trigger immediately (asynchronously). No done pulse is produced.
- IDLE → TRIG takes 1 clock. The trigger output is registered: it rises 1 clock after TRIG entry and is high for exactly DELAY_TRIGGER_US*DELAY_CLK_1US clocks.
- Echo latency: 2 sync clocks plus 1 edge-detect clock from the pin edge to the state change.
- cm count = floor(T_meas / (DELAY_CLK_1US*DELAY_1US_1SM)), where T_meas is the number of clocks spent in MEAS.
- range and timeout update on the same clock edge that asserts done.

## Structure
- Shared package/include holds:
  - FSM state encodings S_IDLE..S_GAP (3-bit).
  - Derived widths: µs counter width from max(DELAY_ECHO_US, DELAY_GAP_US); channel index width.
- Reuse the existing strobe_gen for the µs and cm strobes, adding a synchronous clear input (via its en/rst logic).
- Reuse prm_register_we for the result registers.
- Natural sub-module: sr04_echo_sync. It contains the per-channel 2-flop synchronizer and the rising/falling detect for the selected channel.

## Test plan
Parameters for all scenarios: DELAY_CLK_1US=4, DELAY_1US_1SM=2, DELAY_TRIGGER_US=10, DELAY_ECHO_US=100, DELAY_GAP_US=20, CHANNELS=4.
- **Single echo:** ch_en=4'b0001; echo0 high for 40 clocks starting 10 clocks after trigger falls → trigger0 is high for 40 clocks, range[0]=5, timeout[0]=0, one done pulse with done_ch=0.
- **Round robin:** ch_en=4'b1011 with all echoes answering → trigger order is 0,1,3,0. Channel 2 never triggers. done_ch follows the same order.
- **No echo:** ch_en=4'b0010 and echo1 held low → done 400 clocks after WAIT entry, range[1]=0, timeout[1]=1.
- **Stuck echo:** echo0 rises and never falls → MEAS times out after 400 clocks, range[0]=50, timeout[0]=1.
- **Disable and recover:** ch_en=0 → FSM stays in IDLE and trigger stays 0. Set ch_en=4'b0100 → trigger2 rises 2 clocks later.
- **Reset mid-measurement:** rst_n low during MEAS → all outputs are 0 in the same cycle. After release, the first trigger goes to the lowest enabled channel.

Source files
------------

// File: rtl/sr04_pkg.sv
// Shared definitions for the round-robin HC-SR04 scheduler: FSM encoding and width helpers.
package sr04_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TRIG = 3'd1,
    S_WAIT = 3'd2,
    S_MEAS = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wide enough for the longest state duration counted in microseconds.
  function automatic int us_width(input int echo_us, input int gap_us, input int trig_us);
    int m;
    m = echo_us;
    m = (gap_us > m) ? gap_us : m;
    m = (trig_us > m) ? trig_us : m;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/prm_register_we.sv
// Parameter/result register with write enable, cleared by reset.
module prm_register_we #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] data_q, data_d;

  assign q = data_q;

  // Load on write enable, otherwise hold.
  always_comb begin
    if (we) data_d = d;
    else    data_d = data_q;
  end

  // Storage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end
endmodule

// File: rtl/sr04_echo_sync.sv
// Two-flop synchronizers for every echo pin plus edge detection on the selected channel.
module sr04_echo_sync #(
  parameter int CHANNELS = 4,
  parameter int CW       = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] echo,
  input  logic [CW-1:0]       sel,
  output logic                rise,
  output logic                fall
);
  logic [CHANNELS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic                prev_q, prev_d, cur;

  assign cur  = sync2_q[sel];
  assign rise = cur & ~prev_q;
  assign fall = ~cur & prev_q;

  // Synchronizer chain and previous-level tracking of the selected channel.
  always_comb begin
    sync1_d = echo;
    sync2_d = sync1_q;
    prev_d  = cur;
  end

  // Synchronizer and edge-detect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end
endmodule

// File: rtl/strobe_gen.sv
// Periodic one-cycle strobe every PERIOD clocks; clr or a low en restarts the period.
module strobe_gen #(
  parameter int PERIOD = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic strobe
);
  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign strobe = en && (cnt_q == LAST);

  // Next prescaler value.
  always_comb begin
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/sr04_scheduler.sv
// Round-robin HC-SR04 scheduler: fires one enabled sensor at a time, times its echo in cm
// and stores a per-channel result and timeout flag.
module sr04_scheduler
  import sr04_pkg::*;
#(
  parameter int CHANNELS         = 4,
  parameter int RANGE_WIDTH      = 16,
  parameter int DELAY_CLK_1US    = 50,
  parameter int DELAY_1US_1SM    = 58,
  parameter int DELAY_TRIGGER_US = 10,
  parameter int DELAY_ECHO_US    = 23200,
  parameter int DELAY_GAP_US     = 60000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CHANNELS-1:0]             ch_en,
  input  logic [CHANNELS-1:0]             echo,
  output logic [CHANNELS-1:0]             trigger,
  output logic [CHANNELS*RANGE_WIDTH-1:0] range,
  output logic [CHANNELS-1:0]             timeout,
  output logic                            done,
  output logic [ch_width(CHANNELS)-1:0]   done_ch
);
  localparam int CW = ch_width(CHANNELS);
  localparam int UW = us_width(DELAY_ECHO_US, DELAY_GAP_US, DELAY_TRIGGER_US);
  localparam int RW = RANGE_WIDTH;

  state_t              state_q, state_d;
  logic [CW-1:0]       ch_q, ch_d, done_ch_q, done_ch_d, pick;
  logic [UW-1:0]       us_q, us_d, lim;
  logic [RW-1:0]       cnt_q, cnt_d, cnt_inc, wr_val;
  logic [CHANNELS-1:0] trig_q, trig_d;
  logic                done_q, done_d;
  logic                us_stb, cm_stb, us_end, clr, wr, wr_tmo, rise, fall;
  logic [RW:0]         res_q [CHANNELS];

  strobe_gen #(.PERIOD(DELAY_CLK_1US)) u_us_stb (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(clr), .strobe(us_stb)
  );

  strobe_gen #(.PERIOD(DELAY_CLK_1US * DELAY_1US_1SM)) u_cm_stb (
    .clk(clk), .rst_n(rst_n), .en(state_q == S_MEAS), .clr(clr), .strobe(cm_stb)
  );

  sr04_echo_sync #(.CHANNELS(CHANNELS), .CW(CW)) u_echo_sync (
    .clk(clk), .rst_n(rst_n), .echo(echo), .sel(ch_q), .rise(rise), .fall(fall)
  );

  for (genvar g = 0; g < CHANNELS; g++) begin : g_res
    prm_register_we #(.WIDTH(RW + 1)) u_res (
      .clk(clk), .rst_n(rst_n), .we(wr && (ch_q == CW'(g))),
      .d({wr_tmo, wr_val}), .q(res_q[g])
    );
  end

  // Unpack stored results onto the flat output buses.
  always_comb begin
    range   = '0;
    timeout = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      range[i*RW +: RW] = res_q[i][RW-1:0];
      timeout[i]        = res_q[i][RW];
    end
  end

  // Lowest enabled channel at or above ch_q, wrapping; later (smaller) offsets win.
  always_comb begin
    pick = ch_q;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      pick = ch_en[CW'((int'(ch_q) + i) % CHANNELS)] ? CW'((int'(ch_q) + i) % CHANNELS) : pick;
    end
  end

  // FSM next state, result write decision and counter updates.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    wr      = 1'b0;
    wr_tmo  = 1'b0;
    cnt_inc = (cm_stb && (cnt_q != '1)) ? cnt_q + RW'(1) : cnt_q;
    wr_val  = cnt_inc;
    case (state_q)
      S_TRIG:         lim = UW'(DELAY_TRIGGER_US - 1);
      S_WAIT, S_MEAS: lim = UW'(DELAY_ECHO_US - 1);
      default:        lim = UW'(DELAY_GAP_US - 1);
    endcase
    us_end = us_stb && (us_q == lim);
    case (state_q)
      S_IDLE: begin
        if (ch_en != '0) begin
          state_d = S_TRIG;
          ch_d    = pick;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TRIG: begin
        if (us_end) state_d = S_WAIT;
        else        state_d = S_TRIG;
      end
      S_WAIT: begin
        if (rise) begin
          state_d = S_MEAS;
        end else if (us_end) begin
          state_d = S_GAP;
          wr      = 1'b1;
          wr_tmo  = 1'b1;
          wr_val  = '0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_MEAS: begin
        // Result includes a cm strobe landing in the final MEAS cycle.
        if (fall || us_end) begin
          state_d = S_GAP;
          wr      = 1'b1;
          wr_tmo  = !fall;
        end else begin
          state_d = S_MEAS;
        end
      end
      S_GAP: begin
        if (us_end) begin
          state_d = S_IDLE;
          ch_d    = (ch_q == CW'(CHANNELS - 1)) ? '0 : ch_q + CW'(1);
        end else begin
          state_d = S_GAP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    clr       = (state_d != state_q);
    us_d      = clr ? '0 : (us_stb ? us_q + UW'(1) : us_q);
    cnt_d     = clr ? '0 : cnt_inc;
    trig_d    = '0;
    if (state_q == S_TRIG) trig_d[ch_q] = 1'b1;
    else                   trig_d = '0;
    done_d    = wr;
    done_ch_d = wr ? ch_q : done_ch_q;
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      us_q      <= '0;
      cnt_q     <= '0;
      trig_q    <= '0;
      done_q    <= 1'b0;
      done_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      us_q      <= us_d;
      cnt_q     <= cnt_d;
      trig_q    <= trig_d;
      done_q    <= done_d;
      done_ch_q <= done_ch_d;
    end
  end

  assign trigger = trig_q;
  assign done    = done_q;
  assign done_ch = done_ch_q;
endmodule
